div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit.sv | 111 +++++++++++
 tb/tb_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and types for the iterative divider.
//   DIV_RESULT_BUS  width of the {remainder, quotient} result bus
//   DIV_START/ANNUL active levels of the EX-stage start and annul inputs
//   STALL_STOP/NOSTOP stall-request levels seen by the pipeline controller
//   div_state_e     divider FSM state encoding
package div_unit_pkg;

  localparam int   DIV_RESULT_BUS = 64;
  localparam logic DIV_START      = 1'b1;
  localparam logic DIV_ANNUL      = 1'b1;
  localparam logic STALL_STOP     = 1'b1;
  localparam logic STALL_NOSTOP   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_ZERO = 2'd1,
    ST_BUSY     = 2'd2,
    ST_DONE     = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, one quotient bit per
// clock, MSB first.
//   clk, rst       clock, asynchronous active-high reset
//   start, annul   EX request (held until done), flush of the current op
//   signed_div     1 = two's-complement operands, 0 = unsigned
//   operand_1/2    dividend / divisor, sampled only when an op is accepted
//   result         {remainder, quotient}, held until the next completion
//   done           one-cycle pulse, result valid
//   stall_request  start & ~done & ~annul, to the pipeline controller
module div_unit
  import div_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      annul,
  input  logic                      signed_div,
  input  logic [31:0]               operand_1,
  input  logic [31:0]               operand_2,
  output logic [DIV_RESULT_BUS-1:0] result,
  output logic                      done,
  output logic                      stall_request
);

  div_state_e  state;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;   // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] dvsr;
  logic        q_neg, r_neg;

  // capture-time magnitudes
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // one restoring step
  logic [32:0] shifted, trial, rem_nxt;
  logic [31:0] quo_nxt, q_fix, r_fix;
  logic        ge;

  assign stall_request = start & ~done & ~annul;

  always_comb begin
    a_neg   = signed_div & operand_1[31];
    b_neg   = signed_div & operand_2[31];
    a_mag   = a_neg ? (~operand_1 + 32'd1) : operand_1;
    b_mag   = b_neg ? (~operand_2 + 32'd1) : operand_2;

    shifted = {rem[31:0], quo[31]};
    trial   = shifted - {1'b0, dvsr};
    // remainder stays below the divisor, so a set top bit means the trial went negative
    ge      = ~trial[32];
    rem_nxt = ge ? trial : shifted;
    quo_nxt = {quo[30:0], ge};

    q_fix   = q_neg ? (~quo_nxt + 32'd1)        : quo_nxt;
    r_fix   = r_neg ? (~rem_nxt[31:0] + 32'd1)  : rem_nxt[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      rem    <= 33'd0;
      quo    <= 32'd0;
      dvsr   <= 32'd0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      // done trails the DONE state by one cycle; a flush while in DONE kills it
      done <= (state == ST_DONE) && (annul != DIV_ANNUL);
      if (annul == DIV_ANNUL && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // start is still high from the finished instruction while done is
            // up; it must not launch a second division
            if (start == DIV_START && annul != DIV_ANNUL && !done) begin
              rem   <= 33'd0;
              quo   <= a_mag;
              dvsr  <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= 5'd0;
              state <= (operand_2 == 32'd0) ? ST_DIV_ZERO : ST_BUSY;
            end
          end
          ST_DIV_ZERO: begin
            result <= '0;
            state  <= ST_DONE;
          end
          ST_BUSY: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result <= {r_fix, q_fix};
              state  <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, annul, signed_div;
  logic [31:0] operand_1, operand_2;
  logic [63:0] result;
  logic        done, stall_request;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .annul(annul), .signed_div(signed_div),
    .operand_1(operand_1), .operand_2(operand_2),
    .result(result), .done(done), .stall_request(stall_request)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one op and hold start until done. lat = edges after the capture
  // edge until done is seen; stall_ok = stall_request high until done, low with done.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output bit stall_ok);
    @(negedge clk);
    signed_div = sd; operand_1 = a; operand_2 = b; start = 1'b1; annul = 1'b0;
    lat = -1; stall_ok = 1'b1; res = 'x;
    #1 if (stall_request !== 1'b1) stall_ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done === 1'b1) begin
        res = result;
        if (stall_request !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_request !== 1'b1) stall_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    operand_1 = '0; operand_2 = '0;
    #12;
    n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_request); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; bit ok;
    run_div(1'b0, 32'd100, 32'd7, lat, res, ok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL unsigned_latency got %0d exp 33", lat); end
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL unsigned_result got %h exp %h", res, {32'd2, 32'd14}); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL unsigned_stall got %b exp 1", ok); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, lat, res, ok);
    n_checks++; if (res !== {32'h0000_000F, 32'h0FFF_FFFF}) begin n_fail++; $display("FAIL unsigned_max got %h exp %h", res, {32'h0000_000F, 32'h0FFF_FFFF}); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; bit ok;
    run_div(1'b1, -32'sd7, 32'd2, lat, res, ok);
    n_checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL signed_neg_dividend got %h exp %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL signed_latency got %0d exp 33", lat); end
    run_div(1'b1, 32'd7, -32'sd2, lat, res, ok);
    n_checks++; if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL signed_neg_divisor got %h exp %h", res, {32'h0000_0001, 32'hFFFF_FFFD}); end
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res; bit ok;
    run_div(1'b0, 32'd5, 32'd0, lat, res, ok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL divzero_latency got %0d exp 2", lat); end
    n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL divzero_result got %h exp 0", res); end
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res; bit ok;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
    n_checks++; if (res !== {32'h0, 32'h8000_0000}) begin n_fail++; $display("FAIL overflow_result got %h exp %h", res, {32'h0, 32'h8000_0000}); end
  endtask

  task automatic test_annul_busy();
    int lat; logic [63:0] res; bit ok; int seen;
    seen = 0;
    @(negedge clk);
    signed_div = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd3; start = 1'b1;
    repeat (11) begin @(posedge clk); @(negedge clk); if (done) seen++; end
    annul = 1'b1;
    #1;
    n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL annul_stall got %b exp 0", stall_request); end
    @(posedge clk); @(negedge clk);
    if (done) seen++;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL annul_no_done got %0d pulses exp 0", seen); end
    annul = 1'b0; start = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, lat, res, ok);
    n_checks++; if (res !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_restart got %h exp %h", res, {32'd0, 32'd3}); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL annul_restart_latency got %0d exp 33", lat); end
  endtask

  task automatic test_annul_done();
    int seen;
    seen = 0;
    @(negedge clk);
    signed_div = 1'b0; operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1;
    // capture edge plus 32 steps lands in DONE; flush there
    repeat (33) @(posedge clk);
    @(negedge clk);
    if (done) seen++;
    annul = 1'b1;
    @(posedge clk); @(negedge clk);
    annul = 1'b0; start = 1'b0;
    repeat (40) begin if (done) seen++; @(posedge clk); @(negedge clk); end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL annul_in_done got %0d pulses exp 0", seen); end
  endtask

  task automatic test_start_annul_idle();
    int seen;
    seen = 0;
    @(negedge clk);
    signed_div = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1; annul = 1'b1;
    #1;
    n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL idle_annul_stall got %b exp 0", stall_request); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL idle_annul_no_capture got %0d pulses exp 0", seen); end
  endtask

  task automatic test_operand_change_and_hold();
    int lat;
    @(negedge clk);
    signed_div = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
    @(posedge clk); lat = 0;
    repeat (5) begin @(posedge clk); lat++; end
    @(negedge clk);
    operand_1 = 32'hDEAD_BEEF; operand_2 = 32'd0; signed_div = 1'b1; start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) break;
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL opchange_latency got %0d exp 33", lat); end
    n_checks++; if (result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL opchange_result got %h exp %h", result, {32'd2, 32'd14}); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b exp 0", done); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL result_hold got %h exp %h", result, {32'd2, 32'd14}); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res; bit ok;
    @(negedge clk);
    signed_div = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd10; start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL async_reset_result got %h exp 0", result); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done got %b exp 0", done); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, lat, res, ok);
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL post_reset_result got %h exp %h", res, {32'd2, 32'd14}); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post_reset_latency got %0d exp 33", lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul_busy();
    test_annul_done();
    test_start_annul_idle();
    test_operand_change_and_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
